twiddle_cmul: RTL and testbench

TWIDDLE_CMUL -- requirements
Module: twiddle_cmul

---
 rtl/twiddle_cmul_if.sv | 19 +
 rtl/twiddle_cmul.sv | 105 ++++++++++
 tb/tb_twiddle_cmul.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/twiddle_cmul_if.sv
// Handshake and data bundle for twiddle_cmul: operand set in, Q1.15 complex product out.
interface twiddle_cmul_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ar, ai, wr, wi;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] pr, pi;

  modport slave (
    input  in_valid, ar, ai, wr, wi, out_ready,
    output in_ready, out_valid, pr, pi
  );

  modport master (
    output in_valid, ar, ai, wr, wi, out_ready,
    input  in_ready, out_valid, pr, pi
  );
endinterface

// File: rtl/twiddle_cmul.sv
// Q1.15 complex multiply by a twiddle factor using one shared 16x16 multiplier over four cycles.
// Build option: define TWIDDLE_CMUL_SAT_EN to saturate results instead of wrapping them.
module twiddle_mult16 (
  input  logic signed [15:0] a_i,
  input  logic signed [15:0] b_i,
  output logic signed [31:0] p_o
);
  assign p_o = a_i * b_i;
endmodule

module twiddle_cmul (
  input  logic           clk,
  input  logic           rst,
  twiddle_cmul_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, FIN, OUT} state_t;

  typedef struct packed {
    logic signed [15:0] ar;
    logic signed [15:0] ai;
    logic signed [15:0] wr;
    logic signed [15:0] wi;
  } opnd_t;

  state_t             state_q;
  opnd_t              op_q;
  logic signed [32:0] acc_r_q, acc_i_q;
  logic signed [15:0] pr_q, pi_q, pr_d, pi_d;
  logic               out_valid_q;

  logic signed [15:0] mul_a, mul_b;
  logic signed [31:0] prod;
  logic signed [32:0] prod_ext;

  // Round half up, then narrow to Q1.15 (clamp or keep low 16 bits).
  function automatic logic signed [15:0] rnd_q15(input logic signed [32:0] acc);
`ifdef TWIDDLE_CMUL_SAT_EN
    logic signed [32:0] sh;
    sh = (acc + 33'sd16384) >>> 15;
    if (sh > 33'sd32767)       return 16'sh7FFF;
    else if (sh < -33'sd32768) return 16'sh8000;
    else                       return sh[15:0];
`else
    return 16'((acc + 33'sd16384) >>> 15);
`endif
  endfunction

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      M0:      begin mul_a = op_q.ar; mul_b = op_q.wr; end
      M1:      begin mul_a = op_q.ai; mul_b = op_q.wi; end
      M2:      begin mul_a = op_q.ar; mul_b = op_q.wi; end
      M3:      begin mul_a = op_q.ai; mul_b = op_q.wr; end
      default: ;
    endcase
  end

  twiddle_mult16 u_mult (.a_i(mul_a), .b_i(mul_b), .p_o(prod));

  assign prod_ext = {prod[31], prod};
  assign pr_d     = rnd_q15(acc_r_q);
  assign pi_d     = rnd_q15(acc_i_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      acc_r_q     <= '0;
      acc_i_q     <= '0;
      pr_q        <= '0;
      pi_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          op_q    <= '{ar: bus.ar, ai: bus.ai, wr: bus.wr, wi: bus.wi};
          state_q <= M0;
        end
        M0: begin acc_r_q <= prod_ext;           state_q <= M1;  end
        M1: begin acc_r_q <= acc_r_q - prod_ext; state_q <= M2;  end
        M2: begin acc_i_q <= prod_ext;           state_q <= M3;  end
        M3: begin acc_i_q <= acc_i_q + prod_ext; state_q <= FIN; end
        FIN: begin
          pr_q        <= pr_d;
          pi_q        <= pi_d;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gated by rst so nothing is accepted while reset is still held.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.pr        = pr_q;
  assign bus.pi        = pi_q;
endmodule

// File: tb/tb_twiddle_cmul.sv
// Bench for twiddle_cmul: vector table plus handwritten backpressure and mid-operation reset sequences.
module tb_twiddle_cmul;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  twiddle_cmul_if bus();
  twiddle_cmul dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [15:0] ar, ai, wr, wi, epr, epi;
    string       name;
  } vec_t;

  typedef struct {
    logic [15:0] pr, pi;
    string       name;
  } exp_t;

`ifdef TWIDDLE_CMUL_SAT_EN
  localparam logic [15:0] MAXPOS = 16'h7FFF;
`else
  localparam logic [15:0] MAXPOS = 16'h8000;
`endif

  exp_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint smul(input logic [15:0] a, input logic [15:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  function automatic logic [15:0] ref_q15(input longint acc);
    longint r;
    r = (acc + 64'sd16384) >>> 15;
`ifdef TWIDDLE_CMUL_SAT_EN
    if (r > 64'sd32767) r = 64'sd32767;
    else if (r < -64'sd32768) r = -64'sd32768;
`endif
    return r[15:0];
  endfunction

  // Scoreboard pops one expectation for each output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got pr=%h pi=%h expected no output", bus.pr, bus.pi);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_pr"}, {16'h0, bus.pr}, {16'h0, e.pr});
        chk({e.name, "_pi"}, {16'h0, bus.pi}, {16'h0, e.pi});
      end
    end
  end

  // Called at a negedge; returns at the negedge where out_valid is first seen.
  task automatic send(input vec_t v);
    int n;
    n = 0;
    while (!bus.in_ready && n < 30) begin @(negedge clk); n++; end
    chk({v.name, "_in_ready"}, {31'h0, bus.in_ready}, 32'd1);
    bus.ar = v.ar; bus.ai = v.ai; bus.wr = v.wr; bus.wi = v.wi;
    bus.in_valid = 1'b1;
    sb.push_back('{pr: v.epr, pi: v.epi, name: v.name});
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.ar = 16'($urandom); bus.ai = 16'($urandom);
    bus.wr = 16'($urandom); bus.wi = 16'($urandom);
    n = 1;
    while (!bus.out_valid && n < 30) begin
      chk({v.name, "_busy_in_ready"}, {31'h0, bus.in_ready}, 32'd0);
      @(negedge clk);
      n++;
    end
    chk({v.name, "_latency"}, n, 32'd6);
  endtask

  task automatic run(input vec_t v);
    send(v);
    @(negedge clk);
    chk({v.name, "_done_valid"}, {31'h0, bus.out_valid}, 32'd0);
    chk({v.name, "_done_in_ready"}, {31'h0, bus.in_ready}, 32'd1);
  endtask

  function automatic vec_t mkvec(input logic [15:0] ar, ai, wr, wi, input string nm);
    vec_t v;
    v.ar = ar; v.ai = ai; v.wr = wr; v.wi = wi; v.name = nm;
    v.epr = ref_q15(smul(ar, wr) - smul(ai, wi));
    v.epi = ref_q15(smul(ar, wi) + smul(ai, wr));
    return v;
  endfunction

  initial begin
    logic [15:0] hpr, hpi;
    bit          seen;
    vec_t        v;

    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hpr, hpi;
    bit          seen;

    tbl.push_back('{16'h4000, 16'h0000, 16'h4000, 16'h0000, 16'h2000, 16'h0000, "basic"});
    tbl.push_back('{16'h4000, 16'h4000, 16'h4000, 16'hC000, 16'h4000, 16'h0000, "conj"});
    tbl.push_back('{16'h8000, 16'h0000, 16'h8000, 16'h0000, MAXPOS,   16'h0000, "minmin"});
    tbl.push_back('{16'h0001, 16'h0000, 16'h4000, 16'h0000, 16'h0001, 16'h0000, "rnd_up"});
    tbl.push_back('{16'h0001, 16'h0000, 16'h3FFF, 16'h0000, 16'h0000, 16'h0000, "rnd_dn"});
    tbl.push_back('{16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, "neg_half"});
    tbl.push_back('{16'hFFFF, 16'h0000, 16'h4001, 16'h0000, 16'hFFFF, 16'h0000, "neg_rnd"});
    tbl.push_back('{16'h0000, 16'h4000, 16'h0000, 16'h4000, 16'hE000, 16'h0000, "imag_sq"});
    tbl.push_back('{16'h2000, 16'h4000, 16'h4000, 16'h2000, 16'h0000, 16'h2800, "pi_path"});
    tbl.push_back('{16'h8000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, MAXPOS,   "pi_edge"});

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.ar = '0; bus.ai = '0; bus.wr = '0; bus.wi = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("rst_pr", {16'h0, bus.pr}, 32'd0);
    chk("rst_pi", {16'h0, bus.pi}, 32'd0);
    rst = 1'b0;
    #1 chk("rst_release_in_ready", {31'h0, bus.in_ready}, 32'd1);
    @(negedge clk);

    foreach (tbl[i]) run(tbl[i]);
    for (int i = 0; i < 8; i++)
      run(mkvec(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), $sformatf("rand%0d", i)));

    // Backpressure: hold the result for ten cycles, then release.
    bus.out_ready = 1'b0;
    send(mkvec(16'h1234, 16'hA5A5, 16'h7000, 16'h9000, "bp"));
    hpr = bus.pr; hpi = bus.pi;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid_hold", {31'h0, bus.out_valid}, 32'd1);
      chk("bp_in_ready", {31'h0, bus.in_ready}, 32'd0);
      chk("bp_pr_stable", {16'h0, bus.pr}, {16'h0, hpr});
      chk("bp_pi_stable", {16'h0, bus.pi}, {16'h0, hpi});
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_done_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("bp_done_in_ready", {31'h0, bus.in_ready}, 32'd1);

    // Reset while in M2: the operation must vanish.
    bus.ar = 16'h4000; bus.ai = 16'h4000; bus.wr = 16'h4000; bus.wi = 16'h4000;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", {31'h0, bus.in_ready}, 32'd0);
    chk("mid_rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("mid_rst_pr", {16'h0, bus.pr}, 32'd0);
    chk("mid_rst_pi", {16'h0, bus.pi}, 32'd0);
    rst = 1'b0;
    #1 chk("mid_rst_release_in_ready", {31'h0, bus.in_ready}, 32'd1);
    @(negedge clk);
    seen = 1'b0;
    repeat (8) begin
      seen |= bus.out_valid;
      @(negedge clk);
    end
    chk("mid_rst_no_output", {31'h0, seen}, 32'd0);
    run(mkvec(16'h4000, 16'h0000, 16'h4000, 16'h0000, "post_rst"));

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
